grayscale: RTL and testbench

GRAYSCALE -- requirements
Module: grayscale

---
 rtl/grayscale.sv | 119 +++++++++++
 tb/tb_grayscale.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grayscale.sv
// RGB-to-gray converter: two-stage pipeline between FWFT FIFOs.
// Define GRAYSCALE_WEIGHTED_EN for (77R+150G+29B)>>8 instead of (R+G+B)/3.
module grayscale #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic        clock,
    input  logic        reset,
    output logic        in_rd_en,
    input  logic        in_empty,
    input  logic [23:0] in_dout,
    output logic        out_wr_en,
    input  logic        out_full,
    output logic [7:0]  out_din,
    output logic        frame_done
);

    localparam logic [19:0] LAST = 20'(WIDTH * HEIGHT - 1);

`ifdef GRAYSCALE_WEIGHTED_EN
    localparam int SW = 16;
`else
    localparam int SW = 10;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          valid1;
    logic          valid2;
    logic          pipe_en;
    logic [SW-1:0] sum1;
    logic [SW-1:0] sum_in;
    logic [7:0]    gray1;
    logic [19:0]   rd_cnt;
    logic [19:0]   wr_cnt;
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;

    assign r = in_dout[23:16];
    assign g = in_dout[15:8];
    assign b = in_dout[7:0];

    // A full output stage facing a full FIFO freezes the whole pipe.
    assign pipe_en   = !(valid2 && out_full);
    assign in_rd_en  = (state == RUN) && !in_empty && pipe_en;
    assign out_wr_en = valid2 && !out_full;
    assign frame_done = out_wr_en && (wr_cnt == LAST);

`ifdef GRAYSCALE_WEIGHTED_EN
    assign sum_in = 16'(16'd77 * {8'd0, r})
                  + 16'(16'd150 * {8'd0, g})
                  + 16'(16'd29 * {8'd0, b});
    assign gray1  = sum1[15:8];
`else
    assign sum_in = {2'b00, r} + {2'b00, g} + {2'b00, b};
    assign gray1  = 8'(sum1 / 10'd3);
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state: a frame ends on its last read, then the pipe drains.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (!in_empty) next_state = RUN;
            RUN:     if (in_rd_en && rd_cnt == LAST) next_state = DRAIN;
            DRAIN:   if (!valid1 && !valid2) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Stage 1: capture the partial sum of each popped pixel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid1 <= 1'b0;
            sum1   <= '0;
        end else if (pipe_en) begin
            valid1 <= in_rd_en;
            if (in_rd_en) sum1 <= sum_in;
        end
    end

    // Stage 2: finish the gray value and hold it while the output stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid2  <= 1'b0;
            out_din <= 8'd0;
        end else if (pipe_en) begin
            valid2  <= valid1;
            out_din <= gray1;
        end
    end

    // Read counter: pixels accepted in the current frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)              rd_cnt <= '0;
        else if (state != RUN)  rd_cnt <= '0;
        else if (in_rd_en)      rd_cnt <= rd_cnt + 20'd1;
    end

    // Write counter: wraps on the write that completes a frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)              wr_cnt <= '0;
        else if (frame_done)    wr_cnt <= '0;
        else if (out_wr_en)     wr_cnt <= wr_cnt + 20'd1;
    end

endmodule

// File: tb/tb_grayscale.sv
// Bench for grayscale: FIFO models around the DUT, queue-based
// reference, table vectors and stall/reset/empty-toggle sequences.
module tb_grayscale;

    localparam int W = 4;
    localparam int H = 2;
    localparam int TOTAL = W * H;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_rd_en;
    logic        in_empty = 1'b1;
    logic [23:0] in_dout = '0;
    logic        out_wr_en;
    logic        out_full = 1'b0;
    logic [7:0]  out_din;
    logic        frame_done;

    grayscale #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_rd_en   (in_rd_en),
        .in_empty   (in_empty),
        .in_dout    (in_dout),
        .out_wr_en  (out_wr_en),
        .out_full   (out_full),
        .out_din    (out_din),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [23:0] pix;
        logic [7:0]  exp_avg;
        logic [7:0]  exp_wt;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int wr_total = 0;
    int n_rd = 0;
    int n_wr = 0;
    int n_fd = 0;
    int fd_cyc = 0;
    bit lat_mode = 0;
    logic [23:0] src_q[$];
    logic [7:0]  exp_q[$];
    int          lat_q[$];
    logic [7:0]  wr_log[$];
    int          rd_cyc[$];

    function automatic logic [7:0] gray_ref(input logic [23:0] p);
        int rr, gg, bb;
        rr = int'(p[23:16]);
        gg = int'(p[15:8]);
        bb = int'(p[7:0]);
`ifdef GRAYSCALE_WEIGHTED_EN
        return 8'((77 * rr + 150 * gg + 29 * bb) / 256);
`else
        return 8'((rr + gg + bb) / 3);
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, observe combinational strobes before posedge.
    task automatic step(input bit fe, input bit ff);
        int inflight;
        logic [7:0] e;
        @(negedge clock);
        in_empty = fe || (src_q.size() == 0);
        in_dout  = (src_q.size() != 0) ? src_q[0] : 24'h0;
        out_full = ff;
        #1;
        cyc++;
        inflight = exp_q.size();
        if (inflight > 2) chk("inflight_bound", inflight, 2);
        if (out_full && inflight == 2 && in_rd_en)
            chk("rd_while_stalled", 1, 0);
        if (in_rd_en) begin
            chk("rd_while_empty", int'(in_empty), 0);
            if (!in_empty) begin
                exp_q.push_back(gray_ref(src_q.pop_front()));
                lat_q.push_back(cyc);
                rd_cyc.push_back(cyc);
                n_rd++;
            end
        end
        if (out_wr_en) begin
            if (exp_q.size() == 0) begin
                chk("spurious_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_din", int'(out_din), int'(e));
                if (lat_mode) chk("latency", cyc - lat_q[0], 2);
                void'(lat_q.pop_front());
            end
            chk("frame_done", int'(frame_done),
                int'((wr_total % TOTAL) == TOTAL - 1));
            if (frame_done) begin
                n_fd++;
                fd_cyc = cyc;
            end
            wr_log.push_back(out_din);
            wr_total++;
            n_wr++;
        end else if (frame_done) begin
            chk("frame_done_no_write", 1, 0);
        end
    endtask

    task automatic phase_start();
        n_rd = 0;
        n_wr = 0;
        n_fd = 0;
        wr_log.delete();
        rd_cyc.delete();
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && k < 400) begin
            step(0, 0);
            k++;
        end
        if (k >= 400) chk({name, "_timeout"}, 1, 0);
        repeat (6) step(0, 0);
        chk({name, "_drained"}, exp_q.size() + src_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_out_din", int'(out_din), 0);
        chk("rst_rd_en", int'(in_rd_en), 0);
        chk("rst_wr_en", int'(out_wr_en), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        src_q.delete();
        exp_q.delete();
        lat_q.delete();
        wr_total = 0;
        repeat (3) begin
            @(negedge clock);
            in_empty = 1'b0;
            in_dout  = 24'h123456;
            out_full = 1'b0;
            #1;
            chk("rst_hold_rd", int'(in_rd_en), 0);
            chk("rst_hold_wr", int'(out_wr_en), 0);
        end
        @(negedge clock);
        in_empty = 1'b1;
        reset = 1'b0;
    endtask

    initial begin
        vec_t tbl[8];
        tbl[0] = '{24'h1E3C5A, 8'd60,  8'd54};
        tbl[1] = '{24'hFFFFFF, 8'd255, 8'd255};
        tbl[2] = '{24'h000000, 8'd0,   8'd0};
        tbl[3] = '{24'h010100, 8'd0,   8'd0};
        tbl[4] = '{24'h0A141E, 8'd20,  8'd18};
        tbl[5] = '{24'hFF0000, 8'd85,  8'd76};
        tbl[6] = '{24'h00FF00, 8'd85,  8'd149};
        tbl[7] = '{24'h6465_67, 8'd101, 8'd100};

        #2;
        reset = 1'b1;
        #1;
        chk("init_out_din", int'(out_din), 0);
        chk("init_rd_en", int'(in_rd_en), 0);
        chk("init_wr_en", int'(out_wr_en), 0);
        chk("init_frame_done", int'(frame_done), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Table vectors, one full frame, no stalls.
        phase_start();
        lat_mode = 1;
        foreach (tbl[i]) src_q.push_back(tbl[i].pix);
        drain("table");
        chk("table_writes", n_wr, 8);
        chk("table_fd", n_fd, 1);
        for (int i = 0; i < 8; i++) begin
`ifdef GRAYSCALE_WEIGHTED_EN
            chk($sformatf("table_vec%0d", i), int'(wr_log[i]),
                int'(tbl[i].exp_wt));
`else
            chk($sformatf("table_vec%0d", i), int'(wr_log[i]),
                int'(tbl[i].exp_avg));
`endif
        end
        lat_mode = 0;

        // Ten pixels with the output FIFO full for five cycles.
        phase_start();
        for (int i = 0; i < 10; i++) src_q.push_back(24'($urandom));
        for (int i = 0; i < 12; i++) step(0, (i >= 4 && i < 9));
        drain("stall");
        chk("stall_writes", n_wr, 10);
        chk("stall_fd", n_fd, 1);

        // Flush the partial second frame so the next phase starts clean.
        phase_start();
        for (int i = 0; i < 6; i++) src_q.push_back(24'($urandom));
        drain("flush");
        chk("flush_fd", n_fd, 1);

        // Nine queued pixels: the ninth waits until the frame has ended.
        phase_start();
        for (int i = 0; i < 9; i++) src_q.push_back(24'($urandom));
        drain("frame9");
        chk("frame9_fd", n_fd, 1);
        chk("frame9_writes", n_wr, 9);
        if (rd_cyc.size() == 9)
            chk("ninth_after_done", int'(rd_cyc[8] > fd_cyc), 1);
        else
            chk("frame9_reads", rd_cyc.size(), 9);

        // Reset after three reads, then a clean frame.
        phase_start();
        for (int i = 0; i < 8; i++) src_q.push_back(24'($urandom));
        for (int k = 0; k < 50 && n_rd < 3; k++) step(0, 0);
        chk("pre_reset_reads", n_rd, 3);
        do_reset();
        phase_start();
        for (int i = 0; i < 8; i++) src_q.push_back(24'($urandom));
        drain("post_reset");
        chk("post_reset_writes", n_wr, 8);
        chk("post_reset_fd", n_fd, 1);

        // Input empty every other cycle for a frame.
        phase_start();
        lat_mode = 1;
        for (int i = 0; i < 8; i++) src_q.push_back(24'($urandom));
        for (int k = 0; k < 200 && src_q.size() != 0; k++) step(k[0], 0);
        drain("toggle");
        chk("toggle_writes", n_wr, 8);
        chk("toggle_fd", n_fd, 1);
        lat_mode = 0;

        // Random traffic with random empties and backpressure, five frames.
        phase_start();
        for (int i = 0; i < 5 * TOTAL; i++) src_q.push_back(24'($urandom));
        for (int k = 0; k < 2000 && (src_q.size() != 0 || exp_q.size() != 0);
             k++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        drain("random");
        chk("random_writes", n_wr, 5 * TOTAL);
        chk("random_fd", n_fd, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
